ts_usb_in_arbiter: RTL and testbench

Commit-granular round-robin arbiter between two TS byte FIFOs and the single USB Endpoint 3 IN buffer. Each grant moves exactly `commit_len` bytes from one source FIFO into the EP3 buffer, then runs the commit/acknowledge handshake. It replaces the single-source drain logic when two TS paths must share EP3:
- source 0: main TS FIFO;
- source 1: secondary path, e.g. CAM-out or a second demod.

---
 rtl/ts_usb_in_arbiter_if.sv | 32 +++
 rtl/ts_usb_in_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_ts_usb_in_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ts_usb_in_arbiter_if.sv
// EP3 USB IN buffer bundle: write port, commit/acknowledge handshake and
// buffer-free flag. The arbiter drives it through the master modport and the
// USB endpoint side sees it through the slave modport.
interface ts_usb_in_arbiter_if;
  logic [10:0] ep3_usb_in_addr;
  logic [7:0]  ep3_usb_in_data;
  logic        ep3_usb_in_wren;
  logic        ep3_usb_in_commit;
  logic        ep3_usb_in_ready;
  logic        ep3_usb_in_commit_ack;
  logic [10:0] ep3_usb_in_commit_len;

  modport master (
    output ep3_usb_in_addr,
    output ep3_usb_in_data,
    output ep3_usb_in_wren,
    output ep3_usb_in_commit,
    output ep3_usb_in_commit_len,
    input  ep3_usb_in_ready,
    input  ep3_usb_in_commit_ack
  );

  modport slave (
    input  ep3_usb_in_addr,
    input  ep3_usb_in_data,
    input  ep3_usb_in_wren,
    input  ep3_usb_in_commit,
    input  ep3_usb_in_commit_len,
    output ep3_usb_in_ready,
    output ep3_usb_in_commit_ack
  );
endinterface

// File: rtl/ts_usb_in_arbiter.sv
// Commit-granular round-robin arbiter: two TS byte FIFOs share the EP3 USB IN
// buffer. Each grant copies exactly commit_len bytes from one FIFO into the
// buffer, then raises commit and waits for the (synchronised) acknowledge or
// a timeout. Source 0 wins the first tie after reset.
// Optional feature macro: TS_ARB_STATS_EN builds the per-source byte
// counters bytes0/bytes1; without it both are tied to zero.
module ts_usb_in_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int MAX_LEN = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [10:0]          commit_len,
  input  logic [14:0]          src0_usedw,
  input  logic [7:0]           src0_q,
  output logic                 src0_rdreq,
  input  logic [14:0]          src1_usedw,
  input  logic [7:0]           src1_q,
  output logic                 src1_rdreq,
  ts_usb_in_arbiter_if.master  ep3,
  output logic [1:0]           grant,
  output logic [15:0]          acked,
  output logic [7:0]           timeouts,
  output logic [29:0]          bytes0,
  output logic [29:0]          bytes1
);

  localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [11:0]       MAX_LEN_L = 12'(MAX_LEN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    DRAIN    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  logic [10:0]       len_q;     // commit length latched at grant time
  logic [10:0]       rd_cnt;    // reads issued in the current grant
  logic [10:0]       addr;      // EP3 write address
  logic              wren;      // rdreq delayed one cycle: q is valid now
  logic              commit;
  logic              last;      // 1: source 1 owned the previous commit
  logic [WAIT_W-1:0] wait_cnt;

  logic ack_s1;
  logic ack_s2;
  logic ack_s3;
  logic ack_rise;

  logic len_ok;
  logic elig0;
  logic elig1;
  logic sel;          // source picked if a grant happens this cycle
  logic start;
  logic commit_set;
  logic finish_ack;
  logic finish_to;

  // A source is eligible only when a whole legal commit is already queued
  // and the buffer is free, so READ never has to stall.
  assign len_ok = (commit_len != 11'd0) && ({1'b0, commit_len} <= MAX_LEN_L);
  assign elig0  = len_ok && ep3.ep3_usb_in_ready && (src0_usedw >= {4'd0, commit_len});
  assign elig1  = len_ok && ep3.ep3_usb_in_ready && (src1_usedw >= {4'd0, commit_len});

  // On a tie the source that did not own the last commit wins.
  assign sel = (elig0 && elig1) ? ~last : elig1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode plus the FIFO read strobes and one-cycle event flags.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    next_state = state;
    src0_rdreq = 1'b0;
    src1_rdreq = 1'b0;
    start      = 1'b0;
    commit_set = 1'b0;
    finish_ack = 1'b0;
    finish_to  = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          start      = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        src0_rdreq = grant[0];
        src1_rdreq = grant[1];
        if (rd_cnt == len_q - 11'd1) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        commit_set = 1'b1;
        next_state = WAIT_ACK;
      end
      WAIT_ACK: begin
        // An ack that lands on the timeout cycle still counts as an ack.
        if (ack_rise) begin
          finish_ack = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          finish_to  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Ownership, latched commit length and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= 2'b00;
      len_q <= 11'd0;
      last  <= 1'b1;
    end else if (start) begin
      grant <= sel ? 2'b10 : 2'b01;
      len_q <= commit_len;
    end else if (finish_ack || finish_to) begin
      last  <= grant[1];
      grant <= 2'b00;
    end
  end

  // Read counter: 0..len_q-1 while in READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= 11'd0;
    end else if (start) begin
      rd_cnt <= 11'd0;
    end else if (state == READ) begin
      rd_cnt <= rd_cnt + 11'd1;
    end
  end

  // Write pipeline: wren follows rdreq by one cycle; the address holds at
  // len_q-1 after the last write instead of running past the commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      wren <= 1'b0;
      addr <= 11'd0;
    end else begin
      wren <= src0_rdreq | src1_rdreq;
      if (start) begin
        addr <= 11'd0;
      end else if (wren && (addr != len_q - 11'd1)) begin
        addr <= addr + 11'd1;
      end
    end
  end

  // Commit level and the acknowledge wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      commit   <= 1'b0;
      wait_cnt <= '0;
    end else if (commit_set) begin
      commit   <= 1'b1;
      wait_cnt <= '0;
    end else if (finish_ack || finish_to) begin
      commit   <= 1'b0;
    end else if (state == WAIT_ACK) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // commit_ack comes from the USB clock: two flops for metastability, a
  // third for edge detection, and a registered rising-edge pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_s1   <= 1'b0;
      ack_s2   <= 1'b0;
      ack_s3   <= 1'b0;
      ack_rise <= 1'b0;
    end else begin
      ack_s1   <= ep3.ep3_usb_in_commit_ack;
      ack_s2   <= ack_s1;
      ack_s3   <= ack_s2;
      ack_rise <= ack_s2 & ~ack_s3;
    end
  end

  // Handshake statistics: acked wraps, timeouts saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      acked    <= 16'd0;
      timeouts <= 8'd0;
    end else begin
      if (finish_ack) begin
        acked <= acked + 16'd1;
      end
      if (finish_to && (timeouts != 8'hFF)) begin
        timeouts <= timeouts + 8'd1;
      end
    end
  end

`ifdef TS_ARB_STATS_EN
  // Per-source byte counters, one count per buffer write of the owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      bytes0 <= 30'd0;
      bytes1 <= 30'd0;
    end else if (wren) begin
      if (grant[0]) begin
        bytes0 <= bytes0 + 30'd1;
      end
      if (grant[1]) begin
        bytes1 <= bytes1 + 30'd1;
      end
    end
  end
`else
  assign bytes0 = 30'd0;
  assign bytes1 = 30'd0;
`endif

  // Buffer-side outputs; data is the owning FIFO's read port.
  assign ep3.ep3_usb_in_addr       = addr;
  assign ep3.ep3_usb_in_data       = grant[1] ? src1_q : (grant[0] ? src0_q : 8'd0);
  assign ep3.ep3_usb_in_wren       = wren;
  assign ep3.ep3_usb_in_commit     = commit;
  assign ep3.ep3_usb_in_commit_len = len_q;

endmodule

// File: tb/tb_ts_usb_in_arbiter.sv
// Directed bench for ts_usb_in_arbiter: two modelled source FIFOs with
// distinct data patterns, ack driven by the scenario tasks.
module tb_ts_usb_in_arbiter;

`ifdef TS_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] commit_len;
  logic [14:0] src0_usedw;
  logic [14:0] src1_usedw;
  logic [7:0]  src0_q;
  logic [7:0]  src1_q;
  logic        src0_rdreq;
  logic        src1_rdreq;
  logic [1:0]  grant;
  logic [15:0] acked;
  logic [7:0]  timeouts;
  logic [29:0] bytes0;
  logic [29:0] bytes1;

  ts_usb_in_arbiter_if ep3_bus ();

  ts_usb_in_arbiter #(
    .TIMEOUT(64),
    .MAX_LEN(1024)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .commit_len(commit_len),
    .src0_usedw(src0_usedw),
    .src0_q    (src0_q),
    .src0_rdreq(src0_rdreq),
    .src1_usedw(src1_usedw),
    .src1_q    (src1_q),
    .src1_rdreq(src1_rdreq),
    .ep3       (ep3_bus),
    .grant     (grant),
    .acked     (acked),
    .timeouts  (timeouts),
    .bytes0    (bytes0),
    .bytes1    (bytes1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Source FIFO models: level = lvl - reads, data is a per-source pattern
  // of the read index, presented one cycle after rdreq.
  int rd0 = 0;
  int rd1 = 0;
  int lvl0 = 0;
  int lvl1 = 0;

  function automatic logic [7:0] f0(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] f1(input int i);
    return 8'(i * 13 + 90);
  endfunction

  always @(posedge clk) begin
    if (src0_rdreq === 1'b1) begin
      src0_q <= f0(rd0);
      rd0    <= rd0 + 1;
    end
    if (src1_rdreq === 1'b1) begin
      src1_q <= f1(rd1);
      rd1    <= rd1 + 1;
    end
  end

  assign src0_usedw = (lvl0 > rd0) ? 15'(lvl0 - rd0) : 15'd0;
  assign src1_usedw = (lvl1 > rd1) ? 15'(lvl1 - rd1) : 15'd0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // One full commit: wait for the grant, check the read/write sequence and
  // commit timing, then ack after ack_dly cycles (ack_dly < 0: never ack).
  // new_len != 0 changes commit_len right after the grant.
  task automatic run_commit(input logic [1:0] exp_grant, input int n,
                            input int ack_dly, input int new_len);
    int   waited;
    int   base;
    int   bad_rd;
    int   bad_wr;
    int   hi;
    logic exp_rd;
    logic [7:0] exp_d;
    waited = 0;
    while (grant == 2'b00 && waited < 100) begin
      tick();
      waited++;
    end
    checks++;
    if (grant !== exp_grant) begin
      errors++;
      $display("FAIL grant_owner: got %b expected %b", grant, exp_grant);
    end
    if (grant == 2'b00) return;
    base = exp_grant[1] ? rd1 : rd0;
    if (new_len != 0) commit_len = 11'(new_len);
    bad_rd = 0;
    bad_wr = 0;
    for (int c = 1; c <= n + 1; c++) begin
      if (c > 1) tick();
      exp_rd = (c <= n);
      if (src0_rdreq !== (exp_rd & exp_grant[0]) || src1_rdreq !== (exp_rd & exp_grant[1]))
        bad_rd++;
      if (ep3_bus.ep3_usb_in_wren !== (c >= 2)) begin
        bad_wr++;
      end else if (c >= 2) begin
        exp_d = exp_grant[1] ? f1(base + c - 2) : f0(base + c - 2);
        if (ep3_bus.ep3_usb_in_addr !== 11'(c - 2) || ep3_bus.ep3_usb_in_data !== exp_d)
          bad_wr++;
      end
      if (ep3_bus.ep3_usb_in_commit !== 1'b0) bad_wr++;
    end
    checks++;
    if (bad_rd != 0) begin
      errors++;
      $display("FAIL rdreq_window: got %0d bad cycles expected 0", bad_rd);
    end
    checks++;
    if (bad_wr != 0) begin
      errors++;
      $display("FAIL write_sequence: got %0d bad cycles expected 0", bad_wr);
    end
    tick();
    checks++;
    if (ep3_bus.ep3_usb_in_commit !== 1'b1 || ep3_bus.ep3_usb_in_wren !== 1'b0) begin
      errors++;
      $display("FAIL commit_rise: got commit=%b wren=%b expected 1/0",
               ep3_bus.ep3_usb_in_commit, ep3_bus.ep3_usb_in_wren);
    end
    checks++;
    if (ep3_bus.ep3_usb_in_commit_len !== 11'(n)) begin
      errors++;
      $display("FAIL commit_len_out: got %0d expected %0d", ep3_bus.ep3_usb_in_commit_len, n);
    end
    if (ack_dly >= 0) begin
      for (int i = 0; i < ack_dly; i++) tick();
      ep3_bus.ep3_usb_in_commit_ack = 1'b1;
      waited = 0;
      while (ep3_bus.ep3_usb_in_commit === 1'b1 && waited < 10) begin
        tick();
        waited++;
      end
      checks++;
      if (waited != 4) begin
        errors++;
        $display("FAIL ack_latency: got %0d cycles expected 4", waited);
      end
      ep3_bus.ep3_usb_in_commit_ack = 1'b0;
    end else begin
      hi = 0;
      while (ep3_bus.ep3_usb_in_commit === 1'b1 && hi < 200) begin
        tick();
        hi++;
      end
      checks++;
      if (hi != 65) begin
        errors++;
        $display("FAIL timeout_width: got %0d cycles expected 65", hi);
      end
    end
    checks++;
    if (grant !== 2'b00) begin
      errors++;
      $display("FAIL grant_release: got %b expected 00", grant);
    end
  endtask

  // Watch the DUT for a number of cycles and require it to stay idle.
  task automatic watch_idle(input string name, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (src0_rdreq !== 1'b0 || src1_rdreq !== 1'b0 || grant !== 2'b00 ||
          ep3_bus.ep3_usb_in_wren !== 1'b0 || ep3_bus.ep3_usb_in_commit !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: got %0d active cycles expected 0", name, bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 2'b00 || src0_rdreq !== 1'b0 || src1_rdreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_grant: got grant=%b rd=%b%b expected 00/00", grant, src1_rdreq, src0_rdreq);
    end
    checks++;
    if (ep3_bus.ep3_usb_in_wren !== 1'b0 || ep3_bus.ep3_usb_in_commit !== 1'b0 ||
        ep3_bus.ep3_usb_in_addr !== 11'd0 || ep3_bus.ep3_usb_in_commit_len !== 11'd0) begin
      errors++;
      $display("FAIL reset_ep3: got wren=%b commit=%b addr=%0d len=%0d expected all 0",
               ep3_bus.ep3_usb_in_wren, ep3_bus.ep3_usb_in_commit,
               ep3_bus.ep3_usb_in_addr, ep3_bus.ep3_usb_in_commit_len);
    end
    checks++;
    if (acked !== 16'd0 || timeouts !== 8'd0 || bytes0 !== 30'd0 || bytes1 !== 30'd0) begin
      errors++;
      $display("FAIL reset_counters: got acked=%0d timeouts=%0d b0=%0d b1=%0d expected 0",
               acked, timeouts, bytes0, bytes1);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    commit_len = 11'd188;
    lvl0 = rd0 + 200;
    lvl1 = rd1;
    ep3_bus.ep3_usb_in_ready = 1'b1;
    run_commit(2'b01, 188, 5, 5);
    lvl0 = rd0;
    commit_len = 11'd188;
    checks++;
    if (acked !== 16'd1 || timeouts !== 8'd0) begin
      errors++;
      $display("FAIL single_acked: got acked=%0d timeouts=%0d expected 1/0", acked, timeouts);
    end
    checks++;
    if (bytes0 !== (STATS_ON ? 30'd188 : 30'd0) || bytes1 !== 30'd0) begin
      errors++;
      $display("FAIL single_bytes: got b0=%0d b1=%0d expected %0d/0",
               bytes0, bytes1, STATS_ON ? 188 : 0);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    commit_len = 11'd16;
    lvl0 = rd0 + 32;
    lvl1 = rd1 + 32;
    run_commit(2'b01, 16, 5, 0);
    run_commit(2'b10, 16, 5, 0);
    run_commit(2'b01, 16, 5, 0);
    run_commit(2'b10, 16, 5, 0);
    checks++;
    if (acked !== 16'd4) begin
      errors++;
      $display("FAIL rr_acked: got %0d expected 4", acked);
    end
    checks++;
    if (bytes0 !== (STATS_ON ? 30'd32 : 30'd0) || bytes1 !== (STATS_ON ? 30'd32 : 30'd0)) begin
      errors++;
      $display("FAIL rr_bytes: got b0=%0d b1=%0d expected %0d each",
               bytes0, bytes1, STATS_ON ? 32 : 0);
    end
  endtask

  task automatic test_timeout();
    commit_len = 11'd20;
    lvl0 = rd0 + 40;
    lvl1 = rd1 + 40;
    run_commit(2'b01, 20, -1, 0);
    checks++;
    if (timeouts !== 8'd1 || acked !== 16'd4) begin
      errors++;
      $display("FAIL timeout_counts: got timeouts=%0d acked=%0d expected 1/4", timeouts, acked);
    end
    run_commit(2'b10, 20, 5, 0);
    checks++;
    if (acked !== 16'd5 || timeouts !== 8'd1) begin
      errors++;
      $display("FAIL after_timeout: got acked=%0d timeouts=%0d expected 5/1", acked, timeouts);
    end
  endtask

  task automatic test_ack_at_timeout();
    lvl0 = rd0 + 20;
    lvl1 = rd1;
    run_commit(2'b01, 20, 61, 0);
    lvl0 = rd0;
    checks++;
    if (acked !== 16'd6 || timeouts !== 8'd1) begin
      errors++;
      $display("FAIL ack_tie: got acked=%0d timeouts=%0d expected 6/1", acked, timeouts);
    end
  endtask

  task automatic test_no_grant();
    commit_len = 11'd188;
    lvl0 = rd0 + 187;
    lvl1 = rd1;
    watch_idle("short_fifo", 1000);
    commit_len = 11'd0;
    lvl0 = rd0 + 500;
    lvl1 = rd1 + 500;
    watch_idle("zero_len", 1000);
    commit_len = 11'd1025;
    lvl0 = rd0 + 2000;
    lvl1 = rd1 + 2000;
    watch_idle("over_max_len", 500);
    commit_len = 11'd16;
    lvl0 = rd0 + 500;
    lvl1 = rd1 + 500;
    ep3_bus.ep3_usb_in_ready = 1'b0;
    watch_idle("not_ready", 1000);
    lvl0 = rd0;
    lvl1 = rd1;
    ep3_bus.ep3_usb_in_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int waited;
    commit_len = 11'd188;
    lvl0 = rd0 + 188;
    lvl1 = rd1;
    waited = 0;
    while (!(ep3_bus.ep3_usb_in_wren === 1'b1 && ep3_bus.ep3_usb_in_addr == 11'd99) && waited < 400) begin
      tick();
      waited++;
    end
    checks++;
    if (waited >= 400) begin
      errors++;
      $display("FAIL reach_write_100: got no write at addr 99 within %0d cycles expected one", waited);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (ep3_bus.ep3_usb_in_wren !== 1'b0 || src0_rdreq !== 1'b0 ||
        ep3_bus.ep3_usb_in_commit !== 1'b0 || grant !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_outputs: got wren=%b rd0=%b commit=%b grant=%b expected 0",
               ep3_bus.ep3_usb_in_wren, src0_rdreq, ep3_bus.ep3_usb_in_commit, grant);
    end
    checks++;
    if (acked !== 16'd0 || timeouts !== 8'd0 || bytes0 !== 30'd0 || ep3_bus.ep3_usb_in_addr !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset_counters: got acked=%0d timeouts=%0d b0=%0d addr=%0d expected 0",
               acked, timeouts, bytes0, ep3_bus.ep3_usb_in_addr);
    end
    reset = 1'b0;
    lvl0 = rd0;
    lvl1 = rd1;
    watch_idle("no_commit_after_reset", 300);
    commit_len = 11'd16;
    lvl0 = rd0 + 16;
    lvl1 = rd1 + 16;
    run_commit(2'b01, 16, 5, 0);
    run_commit(2'b10, 16, 5, 0);
    checks++;
    if (acked !== 16'd2) begin
      errors++;
      $display("FAIL post_reset_acked: got %0d expected 2", acked);
    end
  endtask

  initial begin
    reset = 1'b1;
    commit_len = 11'd0;
    ep3_bus.ep3_usb_in_ready = 1'b0;
    ep3_bus.ep3_usb_in_commit_ack = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_ack_at_timeout();
    test_no_grant();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
